// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants for the register-file writeback path: widths, FSM encoding
// and the fixed requester ordering.
package regfile_pkg;

    localparam int XLEN     = 32;
    localparam int REG_AW   = 5;
    localparam int NUM_REGS = 32;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int REQ_ALU  = 0;
    localparam int REQ_LOAD = 1;
    localparam int REQ_CSR  = 2;

endpackage

// File: rtl/regfile_wb_arbiter_rr.sv
// Combinational round-robin picker: the first asserted request at or above ptr,
// wrapping modulo NUM_REQ, returned as a one-hot grant and an encoded index.
module rr_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_vld
);

    logic [IDX_W:0]   idx_wide;
    logic [IDX_W-1:0] idx;

    // ptr < NUM_REQ, so a single conditional subtract is enough to wrap
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        idx_wide  = '0;
        idx       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx_wide = {1'b0, ptr} + (IDX_W+1)'(k);
            if (idx_wide >= (IDX_W+1)'(NUM_REQ)) begin
                idx_wide = idx_wide - (IDX_W+1)'(NUM_REQ);
            end
            idx = idx_wide[IDX_W-1:0];
            if (!grant_vld && req[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = idx;
                grant_vld  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Owns the register-file write port: clears x1..x31 after reset or clear_req,
// then shares the port round-robin between the writeback requesters.
module regfile_wb_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int XLEN    = 32,
    parameter int REG_AW  = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*REG_AW-1:0] req_rd,
    input  logic [NUM_REQ*XLEN-1:0]  req_data,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic                     clear_req,
    output logic                     write_en,
    output logic [REG_AW-1:0]        dst_reg,
    output logic [XLEN-1:0]          data_in,
    output logic                     init_done
);

    import regfile_pkg::*;

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam logic [REG_AW-1:0] CLR_LAST = REG_AW'(NUM_REGS - 1);

    state_t              state;
    logic [REG_AW-1:0]   clr_idx;
    logic [IDX_W-1:0]    rr_ptr;

    logic [NUM_REQ-1:0]  arb_req;
    logic [NUM_REQ-1:0]  grant;
    logic [IDX_W-1:0]    grant_idx;
    logic                grant_vld;
    logic [REG_AW-1:0]   sel_rd;
    logic [XLEN-1:0]     sel_data;
    logic [IDX_W:0]      ptr_inc;
    logic [IDX_W-1:0]    ptr_next;

    // Requests are invisible while clearing and during a clear_req cycle
    assign arb_req   = (state == ST_RUN && !clear_req) ? req_valid : '0;
    assign req_ready = grant;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req       (arb_req),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_vld (grant_vld)
    );

    always_comb begin
        sel_rd   = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_rd   = req_rd[i*REG_AW +: REG_AW];
                sel_data = req_data[i*XLEN +: XLEN];
            end
        end
    end

    assign ptr_inc  = {1'b0, grant_idx} + (IDX_W+1)'(1);
    assign ptr_next = (ptr_inc == (IDX_W+1)'(NUM_REQ)) ? '0 : ptr_inc[IDX_W-1:0];

    // Registered write port stage
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_INIT;
            clr_idx   <= REG_AW'(1);
            rr_ptr    <= '0;
            write_en  <= 1'b0;
            dst_reg   <= '0;
            data_in   <= '0;
            init_done <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    write_en <= 1'b1;
                    dst_reg  <= clr_idx;
                    data_in  <= '0;
                    if (clr_idx == CLR_LAST) begin
                        state     <= ST_RUN;
                        init_done <= 1'b1;
                    end else begin
                        clr_idx <= clr_idx + REG_AW'(1);
                    end
                end
                ST_RUN: begin
                    if (clear_req) begin
                        state     <= ST_INIT;
                        clr_idx   <= REG_AW'(1);
                        init_done <= 1'b0;
                        write_en  <= 1'b0;
                    end else if (grant_vld) begin
                        rr_ptr <= ptr_next;
                        // A grant to x0 is consumed but never reaches the file
                        if (sel_rd != REG_AW'(REG_ZERO)) begin
                            write_en <= 1'b1;
                            dst_reg  <= sel_rd;
                            data_in  <= sel_data;
                        end else begin
                            write_en <= 1'b0;
                        end
                    end else begin
                        write_en <= 1'b0;
                    end
                end
                default: state <= ST_INIT;
            endcase
        end
    end

endmodule
